// File: rtl/fsm_bit_stream_driver.sv
// ============================================================================
// fsm_bit_stream_driver : serialises words MSB-first into an external FSM and
// reports per-word y-code hits. Optional macro: FSM_DRIVER_RESTART_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fsm_bit_stream_driver #(
    parameter int         WIDTH   = 8,
    parameter logic [1:0] MATCH_Y = 2'b11,
    parameter int         CNT_W   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
`ifdef FSM_DRIVER_RESTART_EN
    input  logic             in_restart,
`endif
    output logic             in_ready,
    output logic [2:0]       s_out,
    output logic             x_out,
    input  logic [2:0]       n_in,
    input  logic [1:0]       y_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [2:0]       out_state,
    output logic [1:0]       out_y
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_REPORT = 2'd2,
        ST_HOLD   = 2'd3
    } ctrl_t;

    localparam logic [CNT_W-1:0] C_IDX_LAST = CNT_W'(WIDTH - 1);

    ctrl_t            ctrl_q,   ctrl_d;
    logic [2:0]       fsm_q,    fsm_d;
    logic [WIDTH-1:0] shreg_q,  shreg_d;
    logic [CNT_W-1:0] idx_q,    idx_d;
    logic [CNT_W-1:0] hit_q,    hit_d;
    logic [CNT_W-1:0] ocnt_q,   ocnt_d;
    logic [2:0]       ostate_q, ostate_d;
    logic [1:0]       oy_q,     oy_d;
    logic             w_match;
    logic             w_restart;

`ifdef FSM_DRIVER_RESTART_EN
    assign w_restart = in_restart;
`else
    assign w_restart = 1'b0;
`endif

    assign w_match = (y_in == MATCH_Y);

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= ST_IDLE;
            fsm_q    <= 3'b000;
            shreg_q  <= '0;
            idx_q    <= '0;
            hit_q    <= '0;
            ocnt_q   <= '0;
            ostate_q <= 3'b000;
            oy_q     <= 2'b00;
        end else begin
            ctrl_q   <= ctrl_d;
            fsm_q    <= fsm_d;
            shreg_q  <= shreg_d;
            idx_q    <= idx_d;
            hit_q    <= hit_d;
            ocnt_q   <= ocnt_d;
            ostate_q <= ostate_d;
            oy_q     <= oy_d;
        end
    end

    always_comb begin
        ctrl_d   = ctrl_q;
        fsm_d    = fsm_q;
        shreg_d  = shreg_q;
        idx_d    = idx_q;
        hit_d    = hit_q;
        ocnt_d   = ocnt_q;
        ostate_d = ostate_q;
        oy_d     = oy_q;

        case (ctrl_q)
            ST_IDLE: begin
                if (in_valid) begin
                    shreg_d = in_data;
                    idx_d   = '0;
                    hit_d   = '0;
                    ctrl_d  = ST_SHIFT;
                    if (w_restart) begin
                        fsm_d = 3'b000;
                    end
                end
            end
            ST_SHIFT: begin
                fsm_d   = n_in;
                shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                idx_d   = idx_q + CNT_W'(1);
                // On bit 0, y_in still reflects the state from before this word.
                if ((idx_q != '0) && w_match) begin
                    hit_d = hit_q + CNT_W'(1);
                end
                if (idx_q == C_IDX_LAST) begin
                    ctrl_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                hit_d    = hit_q + CNT_W'(w_match);
                ocnt_d   = hit_q + CNT_W'(w_match);
                ostate_d = fsm_q;
                oy_d     = y_in;
                ctrl_d   = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_ready) begin
                    ctrl_d = ST_IDLE;
                end
            end
            default: begin
                ctrl_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = (ctrl_q == ST_IDLE);
    assign out_valid = (ctrl_q == ST_HOLD);
    assign s_out     = fsm_q;
    assign x_out     = (ctrl_q == ST_SHIFT) ? shreg_q[WIDTH-1] : 1'b0;
    assign out_count = ocnt_q;
    assign out_state = ostate_q;
    assign out_y     = oy_q;

endmodule

`default_nettype wire

// File: tb/tb_fsm_bit_stream_driver.sv
// ============================================================================
// tb_fsm_bit_stream_driver : directed bench with a "1011" detector as the
// external next-state logic. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fsm_bit_stream_driver;

    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_valid = 1'b0;
    logic             in_restart = 1'b0;
    logic             in_ready;
    logic [2:0]       s_out;
    logic             x_out;
    logic [2:0]       n_in;
    logic [1:0]       y_in;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] out_count;
    logic [2:0]       out_state;
    logic [1:0]       out_y;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // External next-state logic: 000 idle, 001 "1", 010 "10", 011 "101".
    always_comb begin
        n_in = 3'b000;
        case (s_out)
            3'b000:  n_in = x_out ? 3'b001 : 3'b000;
            3'b001:  n_in = x_out ? 3'b001 : 3'b010;
            3'b010:  n_in = x_out ? 3'b011 : 3'b000;
            3'b011:  n_in = x_out ? 3'b001 : 3'b010;
            default: n_in = 3'b000;
        endcase
        y_in = (s_out == 3'b011) ? 2'b11 : ((s_out == 3'b010) ? 2'b01 : 2'b00);
    end

    fsm_bit_stream_driver #(
        .WIDTH   (WIDTH),
        .MATCH_Y (2'b11)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
`ifdef FSM_DRIVER_RESTART_EN
        .in_restart(in_restart),
`endif
        .in_ready  (in_ready),
        .s_out     (s_out),
        .x_out     (x_out),
        .n_in      (n_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_state (out_state),
        .out_y     (out_y)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one word and follows it to the result handshake. trace packs the
    // expected state after bit k at [3*k +: 3] (bit 0 in the LSBs).
    task automatic run_word(input logic [7:0] d, input logic rs, input logic [2:0] s0,
                            input logic do_trace, input logic [23:0] trace,
                            input logic [3:0] ecnt, input logic [2:0] est,
                            input logic [1:0] ey, input int hold);
        int n;
        n = 0;
        in_data    = d;
        in_valid   = 1'b1;
        in_restart = rs;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_restart = 1'b0;
        @(negedge clk);
        chk("start_state", 32'(s_out), 32'(s0));
        chk("first_bit", 32'(x_out), 32'(d[7]));
        chk("busy_ready", 32'(in_ready), 32'd0);
        for (int k = 0; k < WIDTH; k++) begin
            @(negedge clk);
            if (do_trace) chk("trace", 32'(s_out), 32'(trace[3*k +: 3]));
            if (k < WIDTH - 1) chk("serial_bit", 32'(x_out), 32'(d[6-k]));
        end
        chk("no_early_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("valid_latency", 32'(out_valid), 32'd1);
        chk("out_count", 32'(out_count), 32'(ecnt));
        chk("out_state", 32'(out_state), 32'(est));
        chk("out_y", 32'(out_y), 32'(ey));
        for (int h = 0; h < hold; h++) begin
            // A word offered while the result is pending must be ignored.
            in_data  = 8'h00;
            in_valid = 1'b1;
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_ready", 32'(in_ready), 32'd0);
            chk("hold_count", 32'(out_count), 32'(ecnt));
            chk("hold_state", 32'(out_state), 32'(est));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_ready", 32'(in_ready), 32'd1);
        chk("release_xout", 32'(x_out), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] bb_trace;
        int          stray;
        // 001,010,011,001,001,010,011,001 for bits 0..7
        bb_trace = {3'b001, 3'b011, 3'b010, 3'b001, 3'b001, 3'b011, 3'b010, 3'b001};

        do_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_s_out", 32'(s_out), 32'd0);
        chk("rst_x_out", 32'(x_out), 32'd0);
        chk("rst_out_count", 32'(out_count), 32'd0);
        chk("rst_out_state", 32'(out_state), 32'd0);
        chk("rst_out_y", 32'(out_y), 32'd0);

        run_word(8'hBB, 1'b0, 3'b000, 1'b1, bb_trace, 4'd2, 3'b001, 2'b00, 0);

        do_reset();
        run_word(8'h00, 1'b0, 3'b000, 1'b1, 24'd0, 4'd0, 3'b000, 2'b00, 0);

        run_word(8'hBB, 1'b0, 3'b000, 1'b1, bb_trace, 4'd2, 3'b001, 2'b00, 5);
        // State carries over: second word starts from 001.
        run_word(8'hBB, 1'b0, 3'b001, 1'b0, 24'd0, 4'd2, 3'b001, 2'b00, 0);

        // Reset while bit 4 is on the wire.
        in_data  = 8'hBB;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_s_out", 32'(s_out), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        chk("midrst_no_result", 32'(stray), 32'd0);
        run_word(8'hBB, 1'b0, 3'b000, 1'b1, bb_trace, 4'd2, 3'b001, 2'b00, 0);

        // From 001: 010,000,000,000,000,001,010,011 -> one hit, ends in 011.
        run_word(8'h05, 1'b0, 3'b001, 1'b1,
                 {3'b011, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010},
                 4'd1, 3'b011, 2'b11, 0);

`ifdef FSM_DRIVER_RESTART_EN
        run_word(8'hBB, 1'b1, 3'b000, 1'b1, bb_trace, 4'd2, 3'b001, 2'b00, 0);
`else
        run_word(8'hBB, 1'b1, 3'b011, 1'b0, 24'd0, 4'd2, 3'b001, 2'b00, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
